// File: rtl/keypad_io_pkg.sv
// Shared constants for keypad_display_io: key map, seven-segment font and
// counter widths.
package keypad_io_pkg;

  localparam int ROW_W   = 2;
  localparam int DIGIT_W = 2;

  // KEY_MAP[row][col]; each 16-bit group is one row, col3 in the top nibble.
  localparam logic [3:0][3:0][3:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  // Active-high gfedcba patterns, SEG_FONT[n] is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sevenseg_mux.sv
// Four-digit multiplexed seven-segment driver: refresh counter, digit select
// and hex font decode with registered active-low outputs.
module sevenseg_mux
  import keypad_io_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [3:0]  grounds,
  output logic [6:0]  display
);

  localparam logic [31:0] REFRESH_LAST = REFRESH_DIV - 1;

  logic [31:0]        refresh_cnt_reg;
  logic [DIGIT_W-1:0] digit_reg;
  logic [3:0]         nibble;

  assign nibble = value[{digit_reg, 2'b00} +: 4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_reg <= '0;
      digit_reg       <= '0;
      grounds         <= 4'b1111;
      display         <= 7'b1111111;
    end else begin
      // Outputs follow the current digit index; the index moves on afterwards.
      grounds <= ~(4'b0001 << digit_reg);
      display <= ~SEG_FONT[nibble];
      if (refresh_cnt_reg == REFRESH_LAST) begin
        refresh_cnt_reg <= '0;
        digit_reg       <= digit_reg + 1'b1;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_display_io.sv
// Keypad scanner with scan-count debounce, CPU read mux and display driver.
// Define KEYPAD_DEBOUNCE_EN for multi-scan debounce; otherwise one scan accepts.
module keypad_display_io
  import keypad_io_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REFRESH_DIV    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  rowwrite,
  input  logic [3:0]  colread,
  input  logic        statusordata,
  input  logic        ack,
  output logic [15:0] keyout,
  input  logic [15:0] seven_seg_data,
  output logic [3:0]  grounds,
  output logic [6:0]  display
);

  localparam logic [31:0] SCAN_LAST = SCAN_DIV - 1;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam logic [31:0] ACCEPT_SCANS = DEBOUNCE_SCANS;
`else
  // DEBOUNCE_SCANS has no effect here: a single sighting is enough.
  localparam logic [31:0] ACCEPT_SCANS = 1 + 0 * DEBOUNCE_SCANS;
`endif

  logic [ROW_W-1:0] row_reg;
  logic [31:0]      scan_cnt_reg;
  logic             found_reg;
  logic [3:0]       cand_reg;
  logic [3:0]       last_reg, last_next;
  logic [31:0]      deb_cnt_reg, deb_cnt_next;
  logic             held_reg, held_next;
  logic [3:0]       keycode_reg;
  logic             valid_reg;

  logic       row_end, scan_end, col_hit, hit, scan_found, accept;
  logic [1:0] col_idx;
  logic [3:0] code_now, scan_code;

  assign rowwrite = ~(4'b0001 << row_reg);
  assign keyout   = statusordata ? {15'b0, valid_reg} : {12'b0, keycode_reg};

  assign row_end  = (scan_cnt_reg == SCAN_LAST);
  assign scan_end = row_end && (row_reg == 2'd3);

  // Lowest active-low column wins.
  always_comb begin
    col_hit = 1'b1;
    col_idx = 2'd0;
    casez (colread)
      4'b???0: col_idx = 2'd0;
      4'b??01: col_idx = 2'd1;
      4'b?011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_hit = 1'b0;
    endcase
  end

  assign code_now   = KEY_MAP[row_reg][col_idx];
  assign hit        = row_end && col_hit;
  assign scan_found = found_reg || hit;
  assign scan_code  = found_reg ? cand_reg : code_now;

  // End-of-scan debounce: an empty scan re-arms, a held key never re-accepts.
  always_comb begin
    accept       = 1'b0;
    deb_cnt_next = deb_cnt_reg;
    last_next    = last_reg;
    held_next    = held_reg;
    if (scan_end) begin
      if (!scan_found) begin
        deb_cnt_next = '0;
        held_next    = 1'b0;
      end else if (!held_reg) begin
        if (deb_cnt_reg != '0 && scan_code == last_reg)
          deb_cnt_next = deb_cnt_reg + 1'b1;
        else
          deb_cnt_next = 32'd1;
        last_next = scan_code;
        if (deb_cnt_next >= ACCEPT_SCANS) begin
          accept       = 1'b1;
          held_next    = 1'b1;
          deb_cnt_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_reg      <= '0;
      scan_cnt_reg <= '0;
      found_reg    <= 1'b0;
      cand_reg     <= '0;
      last_reg     <= '0;
      deb_cnt_reg  <= '0;
      held_reg     <= 1'b0;
      keycode_reg  <= '0;
      valid_reg    <= 1'b0;
    end else begin
      if (row_end) begin
        scan_cnt_reg <= '0;
        row_reg      <= row_reg + 1'b1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end
      if (scan_end) begin
        found_reg <= 1'b0;
      end else if (hit && !found_reg) begin
        found_reg <= 1'b1;
        cand_reg  <= code_now;
      end
      deb_cnt_reg <= deb_cnt_next;
      last_reg    <= last_next;
      held_reg    <= held_next;
      // Acceptance beats a simultaneous ack.
      if (accept) begin
        keycode_reg <= scan_code;
        valid_reg   <= 1'b1;
      end else if (ack) begin
        valid_reg <= 1'b0;
      end
    end
  end

  sevenseg_mux #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_sevenseg (
    .clk     (clk),
    .reset   (reset),
    .value   (seven_seg_data),
    .grounds (grounds),
    .display (display)
  );

endmodule

// File: tb/tb_keypad_display_io.sv
// Randomized bench for keypad_display_io against a scan-history reference model.
module tb_keypad_display_io;

  localparam int SCAN_DIV    = 4;
  localparam int DEB         = 2;
  localparam int REFRESH_DIV = 3;
  localparam int SCAN_CYC    = 4 * SCAN_DIV;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int ACC_SCANS = DEB;
`else
  localparam int ACC_SCANS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rowwrite;
  logic [3:0]  colread;
  logic        statusordata;
  logic        ack;
  logic [15:0] keyout;
  logic [15:0] seven_seg_data;
  logic [3:0]  grounds;
  logic [6:0]  display;

  logic [3:0] pressed [4];

  logic [3:0] km [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                            '{4'h4, 4'h5, 4'h6, 4'hB},
                            '{4'h7, 4'h8, 4'h9, 4'hC},
                            '{4'h0, 4'hF, 4'hE, 4'hD}};
  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: cycles since reset and per-scan history.
  int          m_t;
  int          m_scan_code;
  int          m_streak;
  int          m_streak_code;
  bit          m_armed;
  bit          m_valid;
  logic [3:0]  m_keycode;
  logic [15:0] m_seg;

  keypad_display_io #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .REFRESH_DIV    (REFRESH_DIV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rowwrite       (rowwrite),
    .colread        (colread),
    .statusordata   (statusordata),
    .ack            (ack),
    .keyout         (keyout),
    .seven_seg_data (seven_seg_data),
    .grounds        (grounds),
    .display        (display)
  );

  always #10 clk = ~clk;

  // Physical keypad: a pressed switch shorts its driven row to its column.
  always_comb begin
    colread = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!rowwrite[r]) colread = colread & ~pressed[r];
  end

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_scan_code = -1; m_streak = 0; m_streak_code = 0;
    m_armed = 1'b1; m_valid = 1'b0; m_keycode = 4'h0; m_seg = 16'h0;
  endtask

  task automatic model_step();
    int row, ph, col;
    bit acc;
    logic [3:0] code;
    acc  = 1'b0;
    code = 4'h0;
    row  = (m_t / SCAN_DIV) % 4;
    ph   = m_t % SCAN_DIV;
    if (ph == SCAN_DIV - 1) begin
      col = -1;
      for (int c = 3; c >= 0; c--) if (pressed[row][c]) col = c;
      if (col >= 0 && m_scan_code < 0) m_scan_code = int'(km[row][col]);
      if (row == 3) begin
        if (m_scan_code < 0) begin
          m_streak = 0;
          m_armed  = 1'b1;
        end else begin
          if (m_streak > 0 && m_scan_code == m_streak_code) m_streak++;
          else begin m_streak = 1; m_streak_code = m_scan_code; end
          if (m_armed && m_streak >= ACC_SCANS) begin
            acc = 1'b1; m_armed = 1'b0; code = 4'(m_scan_code);
          end
        end
        m_scan_code = -1;
      end
    end
    if (acc) begin m_valid = 1'b1; m_keycode = code; end
    else if (ack) m_valid = 1'b0;
    m_seg = seven_seg_data;
    m_t++;
  endtask

  task automatic check_all();
    int r, idx;
    logic [3:0] exp_g;
    logic [6:0] exp_d;
    logic [3:0] nib;
    r = (m_t / SCAN_DIV) % 4;
    check_val("rowwrite", 32'(rowwrite), 32'(4'b1111 ^ (4'b0001 << r)));
    if (m_t == 0) begin
      exp_g = 4'b1111; exp_d = 7'h7F;
    end else begin
      idx   = ((m_t - 1) / REFRESH_DIV) % 4;
      nib   = m_seg[idx*4 +: 4];
      exp_g = 4'b1111 ^ (4'b0001 << idx);
      exp_d = ~font[nib];
    end
    check_val("grounds", 32'(grounds), 32'(exp_g));
    check_val("display", 32'(display), 32'(exp_d));
    statusordata = 1'b1;
    #1;
    check_val("status", 32'(keyout), {31'b0, m_valid});
    statusordata = 1'b0;
    #1;
    check_val("data", 32'(keyout), {28'b0, m_keycode});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
  endtask

  task automatic read_key(input logic sod, output logic [15:0] val);
    statusordata = sod;
    #1;
    val = keyout;
    statusordata = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int n, dur;
    reset = 1'b1; ack = 1'b0; statusordata = 1'b0; seven_seg_data = 16'h12AF;
    release_all();
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    ticks(2 * SCAN_CYC);

    // Key 6 at row1/col2.
    pressed[1] = 4'b0100;
    ticks(4 * SCAN_CYC);
    read_key(1'b1, v); check_val("key6_status", 32'(v), 32'h1);
    read_key(1'b0, v); check_val("key6_data", 32'(v), 32'h6);

    // One-cycle ack while still holding: valid must stay clear.
    ack = 1'b1; tick(); ack = 1'b0;
    read_key(1'b1, v); check_val("ack_clear", 32'(v), 32'h0);
    ticks(3 * SCAN_CYC);
    read_key(1'b1, v); check_val("no_repeat", 32'(v), 32'h0);

    // Release, then key 0 at row3/col0.
    release_all(); ticks(2 * SCAN_CYC);
    pressed[3] = 4'b0001; ticks(4 * SCAN_CYC);
    read_key(1'b1, v); check_val("key0_status", 32'(v), 32'h1);
    read_key(1'b0, v); check_val("key0_data", 32'(v), 32'h0);

    // Two columns in row0: lowest column (key 1) wins.
    release_all(); ticks(2 * SCAN_CYC);
    pressed[0] = 4'b1001; ticks(4 * SCAN_CYC);
    read_key(1'b0, v); check_val("multi_col", 32'(v), 32'h1);
    release_all(); ticks(2 * SCAN_CYC);

    // Randomized presses, acks and display values.
    for (int i = 0; i < 60; i++) begin
      release_all();
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) pressed[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
      seven_seg_data = 16'($urandom);
      dur = $urandom_range(1, 5) * SCAN_CYC + $urandom_range(0, SCAN_CYC - 1);
      for (int j = 0; j < dur; j++) begin
        ack = ($urandom_range(0, 15) == 0);
        tick();
      end
      ack = 1'b0;
    end

    // Asynchronous reset mid-scan with valid set; held key re-accepted after.
    release_all(); ticks(2 * SCAN_CYC);
    pressed[1] = 4'b0010; ticks(4 * SCAN_CYC);
    read_key(1'b1, v); check_val("pre_reset_valid", 32'(v), 32'h1);
    ticks(6);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_val("rst_rowwrite", 32'(rowwrite), 32'hE);
    check_val("rst_grounds", 32'(grounds), 32'hF);
    check_all();
    ticks(3);
    reset = 1'b0;
    ticks(4 * SCAN_CYC);
    read_key(1'b1, v); check_val("post_reset_valid", 32'(v), 32'h1);
    read_key(1'b0, v); check_val("post_reset_data", 32'(v), 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
